// File: rtl/rom_readback.sv
// Reads a byte range of the ROM image back from SDRAM as 16-bit words and
// streams it out byte by byte on valid/ready, keeping a running 16-bit checksum.
module rom_readback #(
    parameter int ADDR_W = 25,
    parameter int LEN_W  = 24
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_rdy,
    input  logic [15:0]       sdr_dout,
    output logic [7:0]        rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] addr_inc;
    logic [LEN_W-1:0]  rem_reg, rem_next;
    logic [15:0]       word_reg, word_next;
    logic              abort_hold_reg, abort_hold_next;
    logic [15:0]       checksum_reg, checksum_next;

    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              sdr_req_reg, sdr_req_next;
    logic [ADDR_W-1:0] sdr_addr_reg, sdr_addr_next;
    logic              rb_valid_reg, rb_valid_next;
    logic [7:0]        rb_data_reg, rb_data_next;

    logic [7:0]        word_bytes [2];
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_split
            assign word_bytes[gi] = word_next[gi*8 +: 8];
        end
    endgenerate

    assign accept   = rb_valid_reg & rb_ready;
    assign addr_inc = addr_reg + ADDR_W'(1);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        rem_next        = rem_reg;
        word_next       = word_reg;
        abort_hold_next = abort_hold_reg;
        checksum_next   = checksum_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    checksum_next = '0;
                    if (byte_len != '0) begin
                        addr_next       = base_addr;
                        rem_next        = byte_len;
                        abort_hold_next = 1'b0;
                        state_next      = ST_REQ;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                // An abort here cannot cancel the outstanding read; remember it
                // and drop the returned word instead.
                if (abort) begin
                    abort_hold_next = 1'b1;
                end
                if (sdr_rdy) begin
                    if (abort || abort_hold_reg) begin
                        abort_hold_next = 1'b0;
                        state_next      = ST_IDLE;
                    end else begin
                        word_next  = sdr_dout;
                        state_next = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    checksum_next = checksum_reg + {8'd0, rb_data_reg};
                    addr_next     = addr_inc;
                    rem_next      = rem_reg - LEN_W'(1);
                    if (abort) begin
                        state_next = ST_IDLE;
                    end else if (rem_reg == LEN_W'(1)) begin
                        state_next = ST_DONE;
                    end else if (!addr_inc[0]) begin
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_EMIT;
                    end
                end else if (abort) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        busy_next     = (state_next == ST_REQ) || (state_next == ST_EMIT);
        done_next     = (state_next == ST_DONE);
        sdr_req_next  = (state_next == ST_REQ);
        rb_valid_next = (state_next == ST_EMIT);
        sdr_addr_next = {addr_next[ADDR_W-1:1], 1'b0};
        rb_data_next  = rb_valid_next ? word_bytes[addr_next[0]] : rb_data_reg;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            rem_reg        <= '0;
            word_reg       <= '0;
            abort_hold_reg <= 1'b0;
            checksum_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            sdr_req_reg    <= 1'b0;
            sdr_addr_reg   <= '0;
            rb_valid_reg   <= 1'b0;
            rb_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            rem_reg        <= rem_next;
            word_reg       <= word_next;
            abort_hold_reg <= abort_hold_next;
            checksum_reg   <= checksum_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            sdr_req_reg    <= sdr_req_next;
            sdr_addr_reg   <= sdr_addr_next;
            rb_valid_reg   <= rb_valid_next;
            rb_data_reg    <= rb_data_next;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sdr_req  = sdr_req_reg;
    assign sdr_addr = sdr_addr_reg;
    assign rb_valid = rb_valid_reg;
    assign rb_data  = rb_data_reg;
    assign checksum = checksum_reg;

endmodule

// File: tb/tb_rom_readback.sv
// Self-checking bench for rom_readback: table of transfers checked against a
// byte-level ROM model, plus hand sequences for abort, reset and stray ready.
module tb_rom_readback;

    localparam int ADDR_W = 25;
    localparam int LEN_W  = 24;

    logic              clk = 1'b0;
    logic              RSTn = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  byte_len = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_rdy = 1'b0;
    logic [15:0]       sdr_dout = '0;
    logic [7:0]        rb_data;
    logic              rb_valid;
    logic              rb_ready = 1'b0;
    logic [15:0]       checksum;

    rom_readback #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .RSTn(RSTn), .start(start), .abort(abort),
        .base_addr(base_addr), .byte_len(byte_len),
        .busy(busy), .done(done), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
        .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout),
        .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        int                mode;
        bit                use_words;
        logic [15:0]       w0;
        logic [15:0]       w1;
        int                exp_chk;
        int                restart_at;
    } vec_t;

    int                n_vec = 0;
    int                n_bad = 0;
    logic [7:0]        rom_over [int unsigned];
    bit                ff_mode = 1'b0;
    int                lat_cfg = -1;
    int                ready_mode = 0;
    logic [7:0]        got [$];
    logic [ADDR_W-1:0] req_log [$];
    int                done_cnt = 0;
    int                valid_cnt = 0;
    bit                hold_prev = 1'b0;
    logic [7:0]        hold_data = '0;
    bit                resp_pending = 1'b0;
    int                resp_cnt = 0;
    vec_t              vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ROM contents: explicit overrides, else all 0xFF, else an address hash.
    function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
        int unsigned k;
        logic [31:0] h;
        k = {7'd0, a};
        if (rom_over.exists(k)) return rom_over[k];
        if (ff_mode) return 8'hFF;
        h = k * 32'd2654435761;
        return h[23:16];
    endfunction

    // One clock: monitor at negedge, then drive sink ready and SDRAM model after posedge.
    task automatic tick();
        @(negedge clk);
        if (RSTn) begin
            if (done) done_cnt++;
            if (rb_valid) valid_cnt++;
            if (hold_prev) chk("hold_stable", {31'd0, rb_valid} << 8 | {24'd0, rb_data},
                               {23'd0, 1'b1, hold_data});
            hold_prev = rb_valid && !rb_ready && !abort;
            hold_data = rb_data;
            if (rb_valid && rb_ready) got.push_back(rb_data);
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            0: rb_ready = 1'b1;
            1: rb_ready = ~rb_ready;
            2: rb_ready = 1'($urandom_range(0, 1));
            3: rb_ready = 1'b0;
            default: ;
        endcase
        sdr_rdy = 1'b0;
        if (!sdr_req) begin
            resp_pending = 1'b0;
        end else begin
            if (!resp_pending) begin
                resp_pending = 1'b1;
                resp_cnt = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
            end
            if (resp_cnt == 0) begin
                sdr_rdy  = 1'b1;
                sdr_dout = {rom_byte(sdr_addr + ADDR_W'(1)), rom_byte(sdr_addr)};
                req_log.push_back(sdr_addr);
                resp_pending = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
    endtask

    task automatic run_xfer(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                            input int mode, input int exp_chk, input int restart_at);
        logic [7:0]        exp_q [$];
        logic [ADDR_W-1:0] exp_req [$];
        logic [15:0]       exp_sum;
        logic [ADDR_W-1:0] a;
        int                cyc;
        int                budget;
        bit                seen;
        int                nb;

        exp_sum = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + ADDR_W'(i);
            exp_q.push_back(rom_byte(a));
            exp_sum += {8'd0, rom_byte(a)};
            if (i == 0 || !a[0]) exp_req.push_back({a[ADDR_W-1:1], 1'b0});
        end
        if (exp_chk >= 0) exp_sum = 16'(exp_chk);

        ready_mode = mode;
        got.delete();
        req_log.delete();
        done_cnt = 0;
        base_addr = base;
        byte_len  = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (len != '0) begin
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_req", {31'd0, sdr_req}, 32'd1);
            chk("start_addr", {7'd0, sdr_addr}, {7'd0, exp_req[0]});
        end else begin
            chk("zero_busy", {31'd0, busy}, 32'd0);
            chk("zero_req", {31'd0, sdr_req}, 32'd0);
        end

        budget = int'(len) * 12 + 40;
        cyc = 0;
        seen = (done === 1'b1);
        while (!seen && cyc < budget) begin
            if (cyc == restart_at) begin
                start = 1'b1;
                byte_len = 2;
                base_addr = base + ADDR_W'(100);
            end
            tick();
            start = 1'b0;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_valid", {31'd0, rb_valid}, 32'd0);
        tick();
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("done_count", done_cnt, 32'd1);

        chk("byte_count", got.size(), exp_q.size());
        nb = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < nb; i++) chk("byte_val", {24'd0, got[i]}, {24'd0, exp_q[i]});
        chk("req_count", req_log.size(), exp_req.size());
        nb = (req_log.size() < exp_req.size()) ? req_log.size() : exp_req.size();
        for (int i = 0; i < nb; i++) chk("req_addr", {7'd0, req_log[i]}, {7'd0, exp_req[i]});
        chk("checksum", {16'd0, checksum}, {16'd0, exp_sum});
        $display("xfer base=%h len=%0d mode=%0d bytes=%0d reqs=%0d checksum=%h",
                 base, len, mode, got.size(), req_log.size(), checksum);
    endtask

    task automatic wait_valid(input string name);
        int  cyc;
        cyc = 0;
        while (!rb_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk(name, {31'd0, rb_valid}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{25'h000100, 24'd4, 0, 1'b1, 16'h2211, 16'h4433, 32'h00AA, -1};
        vecs[1] = '{25'h000101, 24'd3, 0, 1'b1, 16'hBBAA, 16'hDDCC, 32'h0264, -1};
        vecs[2] = '{25'h000100, 24'd4, 1, 1'b1, 16'h2211, 16'h4433, 32'h00AA, -1};
        vecs[3] = '{25'h000100, 24'd0, 0, 1'b0, 16'h0000, 16'h0000, 0, -1};
        vecs[4] = '{25'h000200, 24'd8, 0, 1'b0, 16'h0000, 16'h0000, -1, 2};
        vecs[5] = '{25'h1FFFFFD, 24'd6, 2, 1'b0, 16'h0000, 16'h0000, -1, -1};
        for (int i = 6; i < 14; i++) begin
            vecs[i] = '{ADDR_W'($urandom), LEN_W'($urandom_range(1, 12)),
                        int'($urandom_range(0, 2)), 1'b0, 16'h0, 16'h0, -1, -1};
        end

        // Reset state
        #3 RSTn = 1'b0;
        #4;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, sdr_req}, 32'd0);
        chk("rst_addr", {7'd0, sdr_addr}, 32'd0);
        chk("rst_valid", {31'd0, rb_valid}, 32'd0);
        chk("rst_data", {24'd0, rb_data}, 32'd0);
        chk("rst_chk", {16'd0, checksum}, 32'd0);
        @(posedge clk);
        #1 RSTn = 1'b1;
        tick();

        for (int v = 0; v < 14; v++) begin
            logic [ADDR_W-1:0] a0;
            rom_over.delete();
            if (vecs[v].use_words) begin
                a0 = {vecs[v].base[ADDR_W-1:1], 1'b0};
                rom_over[{7'd0, a0}]                = vecs[v].w0[7:0];
                rom_over[{7'd0, a0 + ADDR_W'(1)}]   = vecs[v].w0[15:8];
                rom_over[{7'd0, a0 + ADDR_W'(2)}]   = vecs[v].w1[7:0];
                rom_over[{7'd0, a0 + ADDR_W'(3)}]   = vecs[v].w1[15:8];
            end
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_chk, vecs[v].restart_at);
        end
        rom_over.delete();

        // Checksum wraps modulo 2^16
        ff_mode = 1'b1;
        run_xfer(25'h001000, 24'd258, 0, -1, -1);
        ff_mode = 1'b0;

        // Abort while the read is outstanding: request held until ready, then idle
        lat_cfg = 5;
        ready_mode = 0;
        req_log.delete();
        valid_cnt = 0;
        done_cnt = 0;
        base_addr = 25'h000300;
        byte_len = 24'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("areq_held", {31'd0, sdr_req}, 32'd1);
        begin
            int cyc;
            cyc = 0;
            while (sdr_req && cyc < 20) begin
                tick();
                cyc++;
            end
        end
        chk("areq_rdy_seen", req_log.size(), 32'd1);
        chk("areq_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("areq_no_valid", valid_cnt, 32'd0);
        chk("areq_no_done", done_cnt, 32'd0);
        $display("abort_req reqs=%0d valid_cycles=%0d done=%0d", req_log.size(), valid_cnt, done_cnt);
        lat_cfg = -1;

        // Abort in EMIT together with an accept: byte counted, then idle
        ready_mode = 5;
        rb_ready = 1'b0;
        done_cnt = 0;
        base_addr = 25'h000400;
        byte_len = 24'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("aemit_valid");
        abort = 1'b1;
        rb_ready = 1'b1;
        tick();
        abort = 1'b0;
        rb_ready = 1'b0;
        chk("aemit_valid_drop", {31'd0, rb_valid}, 32'd0);
        chk("aemit_busy", {31'd0, busy}, 32'd0);
        chk("aemit_chk", {16'd0, checksum}, {24'd0, rom_byte(25'h000400)});
        tick();
        tick();
        chk("aemit_no_done", done_cnt, 32'd0);
        $display("abort_emit checksum=%h done=%0d", checksum, done_cnt);

        // Reset mid-EMIT clears outputs immediately; stray ready in idle ignored
        ready_mode = 3;
        base_addr = 25'h000500;
        byte_len = 24'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("rst_mid_valid");
        #2 RSTn = 1'b0;
        #1;
        chk("rmid_valid", {31'd0, rb_valid}, 32'd0);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_req", {31'd0, sdr_req}, 32'd0);
        chk("rmid_data", {24'd0, rb_data}, 32'd0);
        chk("rmid_addr", {7'd0, sdr_addr}, 32'd0);
        chk("rmid_chk", {16'd0, checksum}, 32'd0);
        $display("reset_mid valid=%0d busy=%0d checksum=%h", rb_valid, busy, checksum);
        tick();
        RSTn = 1'b1;
        tick();
        sdr_rdy = 1'b1;
        sdr_dout = 16'hA5A5;
        tick();
        chk("stray_rdy_valid", {31'd0, rb_valid}, 32'd0);
        chk("stray_rdy_busy", {31'd0, busy}, 32'd0);
        run_xfer(25'h000500, 24'd8, 2, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
